// File: rtl/ghostbus_host.sv
// ghostbus_host
//
// Bus initiator for a ghostbus-decoded register hierarchy. Takes one command
// at a time from a host-side stream (UART/Ethernet decoder, sequencer) and
// turns it into a single write strobe or read strobe on the ghostbus. Reads
// wait a fixed latency of RD cycles after the strobe, capture gb_rdata and
// return it on the response channel. Writes return a response with zero data.
//
// Handshakes: a transfer happens on a rising gb_clk edge where both valid and
// ready are high. cmd_ready is high only in IDLE and does not depend on
// cmd_valid. rsp_valid is high only in RESP and, once high, stays high with
// rsp_we/rsp_rdata stable until the edge where rsp_ready is also high.
//
// Parameters:
//   AW  ghostbus address width
//   DW  ghostbus data width
//   RD  read latency (cycles from gb_rstb high to gb_rdata valid), 1..255
//
// Ports:
//   gb_clk, gb_rst_n      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_we, cmd_addr,     command: 1 = write / 0 = read, address, write data
//   cmd_wdata
//   rsp_valid/rsp_ready   response handshake
//   rsp_we, rsp_rdata     response: echoed direction, read data (0 for writes)
//   gb_addr, gb_wdata     bus address / write data, held between transactions
//   gb_wen, gb_rstb       one-cycle write / read strobes
//   gb_rdata              bus read data
//   busy                  high whenever not in IDLE
//   dbg_state             current FSM state encoding
module ghostbus_host #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RD = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WSTB  = 3'd1,
        RSTB  = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [7:0] RD_LOAD = 8'(RD);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lat_cnt;
    logic       we_q;

    // State register
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes, all decoded from the registered state so the
    // strobes are exactly one cycle wide and can never overlap.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        gb_wen    = 1'b0;
        gb_rstb   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // The flop is held in IDLE during reset; gating with the
                // reset input keeps cmd_ready low until release.
                cmd_ready = gb_rst_n;
                if (cmd_valid) begin
                    state_nxt = cmd_we ? WSTB : RSTB;
                end
            end
            WSTB: begin
                gb_wen    = 1'b1;
                state_nxt = RESP;
            end
            RSTB: begin
                gb_rstb   = 1'b1;
                state_nxt = RWAIT;
            end
            RWAIT: begin
                if (lat_cnt <= 8'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            gb_addr   <= '0;
            gb_wdata  <= '0;
            rsp_rdata <= '0;
            we_q      <= 1'b0;
            lat_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        gb_addr <= cmd_addr;
                        we_q    <= cmd_we;
                        // Reads leave the last written data on the bus.
                        if (cmd_we) begin
                            gb_wdata <= cmd_wdata;
                        end
                    end
                end
                WSTB: begin
                    rsp_rdata <= '0;
                end
                RSTB: begin
                    lat_cnt <= RD_LOAD;
                end
                RWAIT: begin
                    // Counter is RD in the first RWAIT cycle, so reaching 1
                    // lands the capture edge RD cycles after the strobe cycle.
                    if (lat_cnt <= 8'd1) begin
                        rsp_rdata <= gb_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_we    = we_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_ghostbus_host.sv
// Testbench for ghostbus_host: directed vectors against an RD=8 instance
// (latency bus model and small memory bus model) and an RD=1 instance.
module tb_ghostbus_host;

    localparam int AW = 24;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;
    logic gb_rst_n;

    // ---------------- RD=8 instance signals ----------------
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata, gb_rdata;
    logic          gb_wen, gb_rstb, busy;
    logic [2:0]    dbg_state;

    // ---------------- RD=1 instance signals ----------------
    logic          cmd_valid1, cmd_ready1, cmd_we1;
    logic [AW-1:0] cmd_addr1;
    logic [DW-1:0] cmd_wdata1;
    logic          rsp_valid1, rsp_ready1, rsp_we1;
    logic [DW-1:0] rsp_rdata1;
    logic [AW-1:0] gb_addr1;
    logic [DW-1:0] gb_wdata1, gb_rdata1;
    logic          gb_wen1, gb_rstb1, busy1;
    logic [2:0]    dbg_state1;

    ghostbus_host #(.AW(AW), .DW(DW), .RD(8)) dut (
        .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    ghostbus_host #(.AW(AW), .DW(DW), .RD(1)) dut1 (
        .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we1),
        .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_we(rsp_we1),
        .rsp_rdata(rsp_rdata1), .gb_addr(gb_addr1), .gb_wdata(gb_wdata1),
        .gb_wen(gb_wen1), .gb_rstb(gb_rstb1), .gb_rdata(gb_rdata1),
        .busy(busy1), .dbg_state(dbg_state1)
    );

    // ---------------- bus models ----------------
    // since_rstb is 1 in the cycle right after a strobe cycle, N in the cycle
    // N cycles after it.
    logic         mem_mode;
    int           since_rstb = 0;
    int           since_rstb1 = 0;
    logic [31:0]  mem [256];

    always @(posedge gb_clk) begin
        if (gb_rstb) since_rstb <= 1;
        else if (since_rstb != 0) since_rstb <= since_rstb + 1;
        if (gb_rstb1) since_rstb1 <= 1;
        else if (since_rstb1 != 0) since_rstb1 <= since_rstb1 + 1;
        if (gb_wen) mem[gb_addr[7:0]] <= gb_wdata;
    end

    assign gb_rdata  = mem_mode ? mem[gb_addr[7:0]]
                                : ((since_rstb == 8) ? 32'h0000_0042 : 32'hFFFF_FFFF);
    assign gb_rdata1 = (since_rstb1 == 1) ? 32'hA5A5_A5A5 : 32'h0000_0000;

    // ---------------- strobe monitor ----------------
    int wen_cnt = 0;
    int rstb_cnt = 0;
    int both_cnt = 0;
    always @(posedge gb_clk) begin
        if (gb_wen) wen_cnt++;
        if (gb_rstb) rstb_cnt++;
        if ((gb_wen && gb_rstb) || (gb_wen1 && gb_rstb1)) both_cnt++;
    end

    // ---------------- scoreboard ----------------
    int          n_total = 0;
    int          n_bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_wen"}, 32'(gb_wen), 0);
        check({tag, "_rstb"}, 32'(gb_rstb), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_we"}, 32'(rsp_we), 0);
        check({tag, "_gb_addr"}, 32'(gb_addr), 0);
        check({tag, "_gb_wdata"}, gb_wdata, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    endtask

    // ---------------- driver tasks ----------------
    // Offers a command from a falling edge and returns #1 after the
    // handshake edge with cmd_valid dropped.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n;
        @(negedge gb_clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge gb_clk);
            n++;
        end
        if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 1);
        @(posedge gb_clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid. start = falling edges already consumed since the
    // handshake edge; returns at the falling edge of the first rsp_valid cycle.
    task automatic wait_rsp(input int start, input int exp_lat, input string tag);
        int k;
        logic [DW-1:0] exp_d;
        k = start;
        do begin
            @(negedge gb_clk);
            k++;
        end while (!rsp_valid && k < 100);
        check({tag, "_lat"}, 32'(k), 32'(exp_lat));
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_0000;
        check({tag, "_rdata"}, rsp_rdata, exp_d);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        gb_rst_n  = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        cmd_valid1 = 1'b0; cmd_we1 = 1'b0; cmd_addr1 = '0; cmd_wdata1 = '0;
        rsp_ready1 = 1'b1;
        mem_mode = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        #2;
        check_reset_outputs("rst");
        repeat (3) @(negedge gb_clk);
        gb_rst_n = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 1);
        check("rel_busy", 32'(busy), 0);

        // Write
        wen_cnt = 0; rstb_cnt = 0;
        send(1'b1, 24'h000010, 32'hDEAD_BEEF);
        @(negedge gb_clk);
        check("wr_wen", 32'(gb_wen), 1);
        check("wr_addr", 32'(gb_addr), 32'h10);
        check("wr_wdata", gb_wdata, 32'hDEAD_BEEF);
        check("wr_rstb", 32'(gb_rstb), 0);
        check("wr_cmd_ready", 32'(cmd_ready), 0);
        exp_q.push_back(32'h0);
        wait_rsp(1, 2, "wr");
        check("wr_rsp_we", 32'(rsp_we), 1);
        check("wr_wen_after", 32'(gb_wen), 0);
        @(negedge gb_clk);
        check("wr_ready_t3", 32'(cmd_ready), 1);
        check("wr_wen_cnt", 32'(wen_cnt), 1);
        check("wr_rstb_cnt", 32'(rstb_cnt), 0);

        // Read latency, RD=8
        wen_cnt = 0; rstb_cnt = 0;
        exp_q.push_back(32'h0000_0042);
        send(1'b0, 24'h000004, 32'h0);
        wait_rsp(0, 10, "rd");
        check("rd_rsp_we", 32'(rsp_we), 0);
        check("rd_rstb_cnt", 32'(rstb_cnt), 1);
        check("rd_wen_cnt", 32'(wen_cnt), 0);
        check("rd_wdata_kept", gb_wdata, 32'hDEAD_BEEF);
        check("rd_addr", 32'(gb_addr), 32'h4);

        // Response backpressure with a second command pending
        @(negedge gb_clk);
        rsp_ready = 1'b0;
        exp_q.push_back(32'h0000_0042);
        send(1'b0, 24'h000008, 32'h0);
        wait_rsp(0, 10, "bp");
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000030; cmd_wdata = 32'h1234_5678;
        wen_cnt = 0; rstb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge gb_clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_rdata", rsp_rdata, 32'h0000_0042);
            check("bp_we", 32'(rsp_we), 0);
            check("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge gb_clk);
        check("bp_acc_ready", 32'(cmd_ready), 1);
        check("bp_wen_cnt", 32'(wen_cnt), 0);
        check("bp_rstb_cnt", 32'(rstb_cnt), 0);
        @(posedge gb_clk);
        #1 cmd_valid = 1'b0;
        @(negedge gb_clk);
        check("bp2_wen", 32'(gb_wen), 1);
        check("bp2_addr", 32'(gb_addr), 32'h30);
        check("bp2_wdata", gb_wdata, 32'h1234_5678);
        exp_q.push_back(32'h0);
        wait_rsp(1, 2, "bp2");
        check("bp2_rsp_we", 32'(rsp_we), 1);

        // Back-to-back write then read against the memory model
        @(negedge gb_clk);
        mem_mode = 1'b1;
        send(1'b1, 24'h000020, 32'h1111_1111);
        exp_q.push_back(32'h0);
        wait_rsp(0, 2, "b2b_wr");
        send(1'b0, 24'h000020, 32'h0);
        @(negedge gb_clk);
        check("b2b_rstb", 32'(gb_rstb), 1);
        check("b2b_wdata_rstb", gb_wdata, 32'h1111_1111);
        exp_q.push_back(32'h1111_1111);
        wait_rsp(1, 10, "b2b_rd");
        check("b2b_wdata_rsp", gb_wdata, 32'h1111_1111);

        // Reset in the third RWAIT cycle
        @(negedge gb_clk);
        mem_mode = 1'b0;
        send(1'b0, 24'h000044, 32'h0);
        repeat (4) @(negedge gb_clk);
        check("mid_pre_state", 32'(dbg_state), 3);
        check("mid_pre_busy", 32'(busy), 1);
        gb_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge gb_clk);
            check("mid_hold_valid", 32'(rsp_valid), 0);
        end
        gb_rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge gb_clk);
            check("mid_no_rsp", 32'(rsp_valid), 0);
        end
        rstb_cnt = 0;
        exp_q.push_back(32'h0000_0042);
        send(1'b0, 24'h000048, 32'h0);
        wait_rsp(0, 10, "post_rst");
        check("post_rst_rstb_cnt", 32'(rstb_cnt), 1);

        // Boundary latency RD=1 on the second instance
        @(negedge gb_clk);
        cmd_valid1 = 1'b1; cmd_we1 = 1'b0; cmd_addr1 = 24'h000055; cmd_wdata1 = 32'h0;
        check("rd1_cmd_ready", 32'(cmd_ready1), 1);
        @(posedge gb_clk);
        #1 cmd_valid1 = 1'b0;
        k = 0;
        do begin
            @(negedge gb_clk);
            k++;
        end while (!rsp_valid1 && k < 50);
        check("rd1_lat", 32'(k), 3);
        check("rd1_rdata", rsp_rdata1, 32'hA5A5_A5A5);
        check("rd1_rsp_we", 32'(rsp_we1), 0);

        @(negedge gb_clk);
        check("no_overlap", 32'(both_cnt), 0);
        check("exp_q_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
